// File: rtl/ni_pkg.sv
// Shared definitions for the network-interface transmit path: flit types,
// flit width, head-flit field layout and the head-payload builder.
package ni_pkg;

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_LOAD
  } pkt_state_e;

  localparam int unsigned FLIT_W        = 66;
  localparam int unsigned HEAD_DEST_LSB = 56;
  localparam int unsigned HEAD_SRC_LSB  = 48;
  localparam int unsigned HEAD_LEN_LSB  = 40;
  localparam int unsigned HEAD_SEQ_LSB  = 32;

  function automatic logic [63:0] make_head(input logic [7:0] dest,
                                            input logic [7:0] src,
                                            input logic [7:0] len,
                                            input logic [7:0] seq);
    logic [63:0] head;
    head = '0;
    head[HEAD_DEST_LSB +: 8] = dest;
    head[HEAD_SRC_LSB  +: 8] = src;
    head[HEAD_LEN_LSB  +: 8] = len;
    head[HEAD_SEQ_LSB  +: 8] = seq;
    return head;
  endfunction

endpackage

// File: rtl/ni_packetizer.sv
// Drains payload words from gp_fifo and emits head/body/tail wormhole flits;
// a packet only starts once its whole payload is already buffered.
module ni_packetizer
  import ni_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned OCUP_W  = 5,
  parameter logic [7:0]  SRC_ID  = 8'h00,
  parameter int unsigned PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fifo_read_en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic [OCUP_W-1:0] fifo_ocup,
  input  logic [7:0]        dest_id,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic              busy,
  output logic [15:0]       pkt_cnt,
  output logic              err
);

  localparam int unsigned REM_W = 5;

  pkt_state_e        state_q, state_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              valid_q, valid_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [7:0]        seq_q, seq_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      flit_q  <= '0;
      valid_q <= 1'b0;
      rem_q   <= '0;
      seq_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      valid_q <= valid_d;
      rem_q   <= rem_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      if (fifo_read_en && fifo_empty) err_q <= 1'b1;
    end
  end

  // rem counts payload words still to fetch; rem == 0 in SEND means the tail is on the wire.
  always_comb begin
    state_d      = state_q;
    flit_d       = flit_q;
    valid_d      = valid_q;
    rem_d        = rem_q;
    seq_d        = seq_q;
    cnt_d        = cnt_q;
    fifo_read_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && fifo_ocup >= OCUP_W'(PKT_LEN)) begin
          flit_d  = {FLIT_HEAD, make_head(dest_id, SRC_ID, 8'(PKT_LEN), seq_q)};
          valid_d = 1'b1;
          rem_d   = REM_W'(PKT_LEN);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (valid_q && flit_ready) begin
          valid_d = 1'b0;
          if (rem_q != '0) begin
            fifo_read_en = 1'b1;
            state_d      = ST_LOAD;
          end else begin
            cnt_d   = cnt_q + 16'd1;
            seq_d   = seq_q + 8'd1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOAD: begin
        flit_d  = {(rem_q == REM_W'(1)) ? FLIT_TAIL : FLIT_BODY, fifo_data};
        valid_d = 1'b1;
        rem_d   = rem_q - REM_W'(1);
        state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flit_out   = flit_q;
  assign flit_valid = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign pkt_cnt    = cnt_q;
  assign err        = err_q;

endmodule

// File: doc/ni_packetizer.md
# ni_packetizer

Transmit-side network-interface stage that drains 64-bit payload words from the NI's `gp_fifo` and emits wormhole packets toward the local router port. Each packet consists of one head flit and `PKT_LEN` payload flits, with the last flit marked as tail. The block sits directly downstream of the FIFO: it drives the FIFO's `read_en` and consumes its `data_out`, `empty` and `ocup`. A packet is started only when the whole payload is already buffered, so a packet never stalls mid-stream on an empty FIFO.

## Interface
- `DATA_W`, 64: payload word width; must equal the FIFO data width.
- `OCUP_W`, 5: FIFO occupancy width.
- `SRC_ID`, 8'h00: this node's ID, placed in the head flit.
- `PKT_LEN`, 4: payload words per packet; legal range 1..16.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_read_en`  out  1  pop request to `gp_fifo`.
- `fifo_data`  in  64  FIFO `data_out`; valid the cycle after `fifo_read_en`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_ocup`  in  5  FIFO occupancy.
- `dest_id`  in  8  destination node ID; sampled at packet start.
- `flit_out`  out  66  flit: bits [65:64] = type, bits [63:0] = payload.
- `flit_valid`  out  1  `flit_out` holds a flit.
- `flit_ready`  in  1  router accepts the flit.
- `busy`  out  1  a packet is in progress.
- `pkt_cnt`  out  16  count of fully sent packets; wraps at 2^16.
- `err`  out  1  sticky underrun flag.

## Operation
- Flit type field: 2'b01 = head, 2'b10 = body, 2'b11 = tail. The value 2'b00 is never emitted.
- Head payload layout:
  - [63:56] `dest_id`
  - [55:48] `SRC_ID`
  - [47:40] `PKT_LEN`
  - [39:32] `seq`, an 8-bit per-packet sequence number that wraps 255 -> 0
  - [31:0] zero
- FSM states: IDLE, SEND, LOAD.
- **IDLE:**
  - Start condition: `!fifo_empty && fifo_ocup >= PKT_LEN`.
  - On start: latch `dest_id`, load the head flit into the output register, set `flit_valid`, set `rem = PKT_LEN`, go to SEND.
- **SEND:** hold `flit_out` and `flit_valid` stable until a transfer (`flit_valid && flit_ready`). On transfer:
  - If `rem != 0`: assert `fifo_read_en` combinationally in that same cycle, clear `flit_valid`, go to LOAD.
  - If `rem == 0`: the tail was just sent. Clear `flit_valid`, increment `pkt_cnt` and `seq`, go to IDLE.
- **LOAD:**
  - Capture `fifo_data` into `flit_out` with type tail if `rem == 1`, otherwise body.
  - Set `flit_valid`, decrement `rem`, go to SEND.
- `fifo_read_en` is asserted only in the SEND transfer cycle described above. It is never asserted in IDLE or LOAD.
- Underrun: if `fifo_empty` is high in a cycle where `fifo_read_en` is asserted, set `err`. The FSM still proceeds (it forwards whatever `fifo_data` holds). `err` clears only on reset.
- `PKT_LEN = 1`: head flit, then a single tail flit.
- `busy` is high whenever state != IDLE.

## Timing
- Reset values: `flit_valid` = 0, `flit_out` = 0, `fifo_read_en` = 0, `busy` = 0, `pkt_cnt` = 0, `seq` = 0, `err` = 0, state = IDLE, `rem` = 0.
- Reset asserted mid-packet: the partial packet is abandoned. No tail is sent. FIFO contents are untouched.
- Start to head flit: the head flit is valid one cycle after the start condition is seen in IDLE.
- Throughput with `flit_ready` held high: one flit every 2 cycles. Head-to-tail span = 2·`PKT_LEN` cycles.
- Backpressure: while `flit_valid && !flit_ready`, `flit_out` stays constant and there is no FIFO pop.
- Back-to-back packets: the next head flit can appear at the earliest 2 cycles after the tail transfer (tail transfer -> IDLE, then start evaluation).
- Dropping `flit_ready` during the head or any body flit stalls only that flit. Ordering and contents are unchanged.
- `dest_id` changes after packet start do not affect the packet in flight.

## Structure
- Shared package `ni_pkg` holds:
  - the flit-type constants `FLIT_HEAD`, `FLIT_BODY`, `FLIT_TAIL`
  - `FLIT_W` = 66
  - head-field bit offsets
  - a `make_head(dest, src, len, seq)` function
- Single module; no sub-module is warranted. The FSM, `rem`, `seq` and `pkt_cnt` counters, and the output register all live in `ni_packetizer`.

## Test plan
- **Single packet:** `PKT_LEN` = 4, preload 4 words 64'h11..11–64'h44..44, `dest_id` = 8'h05, `flit_ready` = 1.
  - Expect the head {01, 64'h0500_0400_0000_0000}, then body 11.., 22.., 33.., then tail 44...
  - Expect 4 pops, `pkt_cnt` = 1, `busy` low after the tail.
- **Insufficient data:** preload 3 words with `PKT_LEN` = 4 -> no head, no pop, `busy` = 0. Push a 4th word -> head appears 1 cycle after `fifo_ocup` reaches 4.
- **Backpressure:** hold `flit_ready` = 0 for 5 cycles on the second body flit -> `flit_out` is constant, `fifo_read_en` = 0 throughout, and the packet resumes intact.
- **Back-to-back and sequence wrap:** preload 8 words and send 2 packets -> `seq` fields are 0 then 1 and `pkt_cnt` = 2. Force `seq` through 256 packets -> the field wraps 255 -> 0.
- **`PKT_LEN` = 1:** head flit then a single tail flit; exactly one pop per packet.
- **Reset mid-packet:** assert `reset` after the head transfer -> all outputs take their reset values immediately. After release, the next packet starts with `seq` = 0 using the remaining FIFO data.
